alu_req_arbiter: RTL
====================

# alu_req_arbiter

Two-port request arbiter and sequencer for the shared 16-bit `ALU_TOP` datapath. Two independent requesters submit `{A, B, ALU_FUN}` operations over valid/ready handshakes. The block grants the datapath round-robin, drives the ALU operand/function inputs, and captures the registered result one cycle later from the unit selected by `ALU_FUN[3:2]`. It returns the result, carry, error and requester tag over a single valid/ready response channel.

## Interface
- `WIDTH`, 16, operand/result width; equals `ALU_TOP.In_out`.
- `CLK`  in  1  single clock; all state on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  requester N (N=0,1) has an operation pending.
- `reqN_ready`  out  1  combinational grant; the operation is accepted on the edge where valid&ready.
- `reqN_a`, `reqN_b`  in  WIDTH  operands of requester N.
- `reqN_fun`  in  4  ALU_FUN of requester N.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to `ALU_TOP.A/B`.
- `alu_fun`  out  4  registered function code to `ALU_TOP.ALU_FUN`.
- `arith_out`, `logic_out`, `cmp_out`, `shift_out`  in  WIDTH  unit results from `ALU_TOP`.
- `carry_in`  in  1  `ALU_TOP.Carry_OUT`.
- `arith_flag`, `logic_flag`, `cmp_flag`, `shift_flag`  in  1  unit-valid flags from `ALU_TOP`.
- `rsp_valid`  out  1  response held valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester index of the response.
- `rsp_data`  out  WIDTH  selected unit result.
- `rsp_carry`  out  1  `carry_in` for the arithmetic class; 0 for all other classes.
- `rsp_err`  out  1  selected unit flag was low at capture.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Unit class** from `ALU_FUN[3:2]`: 00 arith, 01 logic, 10 cmp, 11 shift.
- **FSM states**: IDLE, EXEC, CAPT, RESP.
- **IDLE**
  - `reqN_ready` is asserted only here, for at most one requester.
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester other than `last_id` is granted.
  - On grant: latch `alu_a`/`alu_b`/`alu_fun` from the winner, store `id` ← winner, `last_id` ← winner, go to EXEC.
- **EXEC**: ALU inputs are stable; `ALU_TOP` registers the result at the end of this cycle. Go to CAPT unconditionally.
- **CAPT**: mux the unit output by class into `rsp_data`. Set `rsp_carry` per class rule, `rsp_err` = !flag of the selected class, `rsp_id` = id. Set `rsp_valid` ← 1 and go to RESP.
- **RESP**: hold all `rsp_*` stable while `rsp_valid & !rsp_ready`. On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- `alu_a`, `alu_b` and `alu_fun` hold their last values outside EXEC/CAPT; they change only on a grant.
- A requester that deasserts valid without being granted loses nothing. Operands are sampled only on the grant edge.

## Timing
- **Reset values**: state=IDLE; `last_id`=1, so requester 0 wins the first tie. `alu_a`, `alu_b`, `alu_fun`, `rsp_data` = 0. `rsp_valid`, `rsp_id`, `rsp_carry`, `rsp_err`, `busy` = 0. `reqN_ready`=0 while `RST` is low.
- **Latency**: the grant edge is edge 0. `rsp_valid` rises after edge 2, i.e. 3 cycles from acceptance to response.
- **Throughput**: with `rsp_ready` held high, the next grant occurs at edge 4, giving one operation per 4 cycles.
- **Back-pressure**: RESP may last indefinitely. No new grant is issued until the response is accepted.
- **Simultaneous events**: a request arriving in the same cycle as RESP acceptance is not granted until the following IDLE cycle. There is no IDLE bypass.
- **Fairness**: with both requesters continuously valid, grants strictly alternate.
- **Reset mid-operation**: asynchronous reset in EXEC, CAPT or RESP drops the in-flight operation with no response. All outputs go to reset values immediately.
- **Unknown flags**: `rsp_err` is computed only from the selected class. Flags of other units are ignored.

## Test plan
- **Reset**: assert `RST`=0 mid-EXEC → `rsp_valid`=0, `busy`=0, `alu_fun`=0 immediately. After release, first tie grants requester 0.
- **Single add**: req0 A=0x0005, B=0x0003, fun=0000, arith_flag=1 → `req0_ready` in the grant cycle. Three cycles later `rsp_valid`=1, `rsp_data`=0x0008, `rsp_id`=0, `rsp_carry`=0, `rsp_err`=0.
- **Carry**: req1 A=0xFFFF, B=0x0001, fun=0000 → `rsp_data`=0x0000, `rsp_carry`=1, `rsp_id`=1.
  - Same operands with a logic fun (0100) → `rsp_carry`=0 regardless of `carry_in`.
- **Arbitration**: both requesters valid for 8 operations → grants 0,1,0,1,0,1,0,1, and each `rsp_id` matches its grant.
- **Back-pressure**: hold `rsp_ready`=0 for 10 cycles → `rsp_*` stable and no `reqN_ready` pulses. Release → the next grant is 1 cycle after acceptance.
- **Flag error**: shift class (fun=1100) with shift_flag forced 0 at CAPT → `rsp_err`=1 and `rsp_data`=`shift_out`. The next operation with flag=1 → `rsp_err`=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//
// Two-port request arbiter and sequencer for the shared 16-bit ALU_TOP
// datapath. Two requesters submit {A, B, ALU_FUN} operations over
// valid/ready handshakes. The block grants the datapath round-robin, drives
// the ALU inputs, and captures the registered unit result selected by
// ALU_FUN[3:2]. It returns that result over one valid/ready response channel.
//
// Ports
//   CLK, RST                      clock, asynchronous active-low reset
//   req0_* / req1_*               valid, ready (comb grant), a, b, fun
//   alu_a, alu_b, alu_fun         registered operands/function to ALU_TOP
//   arith/logic/cmp/shift_out     unit results from ALU_TOP
//   carry_in                      ALU_TOP carry out
//   arith/logic/cmp/shift_flag    unit-valid flags from ALU_TOP
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_data, rsp_carry, rsp_err  response payload
//   busy                          high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_fun,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_fun,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,

  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             carry_in,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,

  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] CLASS_ARITH = 2'b00;
  localparam logic [1:0] CLASS_LOGIC = 2'b01;
  localparam logic [1:0] CLASS_CMP   = 2'b10;
  localparam logic [1:0] CLASS_SHIFT = 2'b11;

  state_t state;
  state_t state_nxt;

  logic             last_id;
  logic             cur_id;
  logic             win_any;
  logic             win_id;
  logic             grant;
  logic [WIDTH-1:0] sel_data;
  logic             sel_flag;
  logic             sel_carry;

  // Winner selection. On a tie the requester that was not served last wins,
  // which makes grants strictly alternate under continuous contention.
  always_comb begin
    win_any = req0_valid | req1_valid;
    win_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      win_id = ~last_id;
    end else if (req1_valid) begin
      win_id = 1'b1;
    end
  end

  // A grant can only happen in IDLE; RESP always returns to IDLE first, so
  // a request arriving alongside response acceptance waits one cycle.
  assign grant = (state == IDLE) && win_any;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: EXEC and CAPT are fixed single-cycle steps that line up
  // with the one-cycle registered latency inside ALU_TOP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (grant)     state_nxt = EXEC;
      EXEC:                state_nxt = CAPT;
      CAPT:                state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Output logic. Ready is gated by RST so that no handshake completes while
  // the block is held in reset, even though the state already reads IDLE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (RST && grant) begin
      req0_ready = ~win_id;
      req1_ready = win_id;
    end
    busy = (state != IDLE);
  end

  // Result selection by unit class. Only the selected unit's flag is looked
  // at, so undriven or unknown flags of the other units cannot leak into
  // the error bit. Carry is meaningful only for the arithmetic unit.
  always_comb begin
    sel_data  = arith_out;
    sel_flag  = arith_flag;
    sel_carry = 1'b0;
    unique case (alu_fun[3:2])
      CLASS_ARITH: begin
        sel_data  = arith_out;
        sel_flag  = arith_flag;
        sel_carry = carry_in;
      end
      CLASS_LOGIC: begin
        sel_data  = logic_out;
        sel_flag  = logic_flag;
      end
      CLASS_CMP: begin
        sel_data  = cmp_out;
        sel_flag  = cmp_flag;
      end
      CLASS_SHIFT: begin
        sel_data  = shift_out;
        sel_flag  = shift_flag;
      end
      default: begin
        sel_data  = arith_out;
        sel_flag  = arith_flag;
      end
    endcase
  end

  // Request-side registers. Operands are sampled only on the grant edge and
  // otherwise hold, so ALU_TOP sees stable inputs through EXEC and CAPT.
  // last_id resets to 1 so that requester 0 wins the very first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= 4'd0;
      cur_id  <= 1'b0;
      last_id <= 1'b1;
    end else if (grant) begin
      alu_a   <= win_id ? req1_a   : req0_a;
      alu_b   <= win_id ? req1_b   : req0_b;
      alu_fun <= win_id ? req1_fun : req0_fun;
      cur_id  <= win_id;
      last_id <= win_id;
    end
  end

  // Response registers. The payload is loaded once at the end of CAPT and
  // then frozen for however long the consumer stalls in RESP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == CAPT) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        rsp_data  <= sel_data;
        rsp_carry <= sel_carry;
        rsp_err   <= ~sel_flag;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
